uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receive path of the UART: oversamples the RX pin, reassembles 8N1 frames LSB-first and queues received bytes in a small show-ahead FIFO that the bus side drains. It is the counterpart of the TX FIFO/shifter path. It runs entirely in the master clock domain (12 MHz reference).

Parameters:
CLK_HZ, 12000000, master clock frequency in Hz
BAUD, 115200, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit (power of two, >= 8)
FIFO_DEPTH, 16, RX FIFO entries (power of two, >= 2)

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-low reset
rx_bit  in  1  RX UART pin, asynchronous, idles high
rd_en  in  1  pop head of FIFO this cycle
rd_data  out  8  FIFO head byte (show-ahead)
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full
rx_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued
overrun  out  1  sticky: byte dropped because FIFO was full
frame_err  out  1  sticky: stop bit sampled low
clr_err  in  1  clears overrun and frame_err

Behaviour:
- Reset (reset low, asynchronous): FSM IDLE, both synchronizer flops 1, FIFO empty, rx_count 0, rx_empty 1, rx_full 0, rd_data 0, overrun 0, frame_err 0.
- rx_bit passes through a 2-flop synchronizer (rxs). All decisions use rxs.
- Tick divider: DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)), minimum 1. A one-cycle sample_tick fires every DIV clocks. The divider is free-running, except that it restarts on entry to START.
- Sample counter sc is 0..OVERSAMPLE-1 and advances on each sample_tick. Each bit value is the majority vote of the samples at sc = M-1, M and M+1, where M = OVERSAMPLE/2.
- IDLE: rxs==0 -> START, with sc=0 and the bit counter cleared.
- START: at sc=M+1 the vote is evaluated. A vote of 1 is a false start and returns to IDLE with nothing pushed. A vote of 0 continues, and the FSM moves to DATA at the sc wrap.
- DATA: 8 bits are shifted LSB-first into the shift register, one vote per bit, and each bit ends at its sc wrap. After bit 7 -> STOP (or PARITY when UART_RX_PARITY_EN is defined).
- STOP: the vote is evaluated at sc=M+1.
  - Vote 1: the byte is pushed into the FIFO on that same clock, then IDLE. The FSM leaves at mid-stop so it can resync to a back-to-back frame.
  - Vote 0: frame_err is set, the byte is discarded, then WAIT_IDLE.
- WAIT_IDLE: stays until rxs==1, then IDLE. A break condition therefore produces exactly one frame_err and no bytes.
- FIFO (show-ahead):
  - rd_data equals the head entry whenever rx_empty==0.
  - rd_en pops on the clock edge; rd_en while empty is ignored.
  - A push makes rx_empty deassert on the next clock, so the byte is visible one clock after the mid-stop sample.
  - Push while full and without pop: the byte is dropped, overrun is set and contents are unchanged.
  - Push and pop in the same cycle: both take effect, including when full, and rx_count is unchanged. A simultaneous push and pop while empty leaves the pushed byte in the FIFO and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_full = (rx_count == FIFO_DEPTH).
- Error flags: sticky. clr_err clears both flags, but a new error in the same cycle wins and the flag stays 1.
- Reset mid-frame: everything returns to reset values, and the next falling edge after reset release is treated as a new start bit.

Optional Feature:
UART_RX_PARITY_EN: adds a PARITY state between DATA and STOP and an output parity_err (sticky, also cleared by clr_err).
- The parity bit is voted like a data bit. With odd_parity low, even parity is checked: XOR of the 8 data bits and the parity bit must be 0. With odd_parity high, odd parity is checked.
- On mismatch, parity_err is set and the byte is discarded; the stop bit is still checked.
- odd_parity is a 1-bit input port present only when the macro is defined.
Without the macro the block is 8N1 only, and neither parity_err nor odd_parity exists.

Decomposition:
- Package uart_pkg holds:
  - the FSM state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
  - the DATA_BITS=8 constant;
  - the DIV computation function, shared with the TX path.
- One sub-module, uart_rx_fifo, a synchronous show-ahead FIFO:
  - parameter DEPTH;
  - ports push/din/pop/dout/empty/full/count;
  - it sets no error flags itself, because the parent derives overrun.

Test Plan:
- Send 0x41 at BAUD with correct bit timing -> one bit-time after the start edge + 9.5 bit-times: rx_empty=0, rd_data=0x41, rx_count=1; after rd_en, rx_empty=1.
- Pulse rx_bit low for 3 sample ticks only -> FSM returns to IDLE, rx_count stays 0, no error flags.
- Frame 0x55 with stop bit driven low, then line high -> frame_err=1, FIFO empty; clr_err -> frame_err=0.
- Send 17 bytes 0x00..0x10 with no reads (FIFO_DEPTH=16) -> rx_full=1, overrun=1; reading yields 0x00..0x0F in order, and 0x10 is lost.
- Back-to-back frames 0x00, 0xFF, 0xA5 with no idle gap, and rd_en asserted on the push cycle of the 2nd byte -> all three bytes received in order and no overrun.
- Assert reset mid-DATA of 0x3C, release, then send 0x96 -> all outputs at reset values during reset; only 0x96 is received.
- With UART_RX_PARITY_EN, even parity, 0x07 sent with parity bit 0 -> parity_err=1 and no byte; with parity bit 1 -> 0x07 is received.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types: receive FSM encoding, frame width and the
//               baud tick divider calculation used by both RX and TX paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_state_t;

    // Rounded CLK_HZ / (BAUD * OVERSAMPLE), never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int rate;
        int div;
        rate = baud * oversample;
        div  = (clk_hz + rate / 2) / rate;
        return (div < 1) ? 1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous show-ahead byte FIFO; head is visible on dout
//               whenever the FIFO is not empty, 0 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_DEPTH);
    assign count     = r_count;
    assign dout      = empty ? 8'h00 : r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 UART receiver with show-ahead RX FIFO and
//               sticky error flags. Define UART_RX_PARITY_EN for a parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_bit,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rx_empty,
    output logic                        rx_full,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        overrun,
    output logic                        frame_err,
`ifdef UART_RX_PARITY_EN
    input  logic                        odd_parity,
    output logic                        parity_err,
`endif
    input  logic                        clr_err
);

    localparam int                 c_DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                 c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int                 c_SC_W     = $clog2(OVERSAMPLE);
    localparam int                 c_MID      = OVERSAMPLE / 2;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_SC_W-1:0]  c_SC_ONE   = c_SC_W'(1);
    localparam logic [c_SC_W-1:0]  c_SC_S0    = c_SC_W'(c_MID - 1);
    localparam logic [c_SC_W-1:0]  c_SC_S1    = c_SC_W'(c_MID);
    localparam logic [c_SC_W-1:0]  c_SC_VOTE  = c_SC_W'(c_MID + 1);
    localparam logic [c_SC_W-1:0]  c_SC_LAST  = c_SC_W'(OVERSAMPLE - 1);
    localparam logic [2:0]         c_BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_t        c_AFTER_DATA = PARITY;
`else
    localparam uart_state_t        c_AFTER_DATA = STOP;
`endif

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [1:0]           r_sync;
    logic                 w_rxs;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic                 w_tick;
    logic [c_SC_W-1:0]    r_sc;
    logic [1:0]           r_samp;
    logic                 w_vote;
    logic                 w_vote_tick;
    logic                 w_wrap;
    logic                 w_start_det;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 w_push;
    logic                 w_set_ferr;
    logic                 w_overrun_evt;

    assign w_rxs       = r_sync[1];
    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_start_det = (r_state == IDLE) && !w_rxs;
    assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxs) | (r_samp[1] & w_rxs);
    assign w_vote_tick = w_tick && (r_sc == c_SC_VOTE);
    assign w_wrap      = w_tick && (r_sc == c_SC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_bit};
        end
    end

    // Restarting the divider on the start edge phase-aligns sampling to the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_start_det || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sc      <= '0;
            r_samp    <= 2'b11;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start_det) begin
                r_sc      <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_tick) begin
                    r_sc <= r_sc + c_SC_ONE;
                end
                if (r_state == DATA && w_wrap) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end
            if (w_tick && r_sc == c_SC_S0) begin
                r_samp[0] <= w_rxs;
            end
            if (w_tick && r_sc == c_SC_S1) begin
                r_samp[1] <= w_rxs;
            end
            if (r_state == DATA && w_vote_tick) begin
                r_shift <= {w_vote, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_mismatch;
    logic w_set_perr;
    logic r_par_bad;

    assign w_par_mismatch = (^{r_shift, w_vote}) ^ odd_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (w_start_det) begin
                r_par_bad <= 1'b0;
            end else if (w_set_perr) begin
                r_par_bad <= 1'b1;
            end
            if (w_set_perr) begin
                parity_err <= 1'b1;
            end else if (clr_err) begin
                parity_err <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_set_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_set_perr  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_vote_tick && w_vote) begin
                    w_state_nxt = IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_wrap && r_bit_cnt == c_BIT_LAST) begin
                    w_state_nxt = c_AFTER_DATA;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_vote_tick && w_par_mismatch) begin
                    w_set_perr = 1'b1;
                end
`endif
                if (w_wrap) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (w_vote_tick) begin
                    if (w_vote) begin
`ifdef UART_RX_PARITY_EN
                        w_push = !r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = IDLE;
                    end else begin
                        w_set_ferr  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rxs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_overrun_evt = w_push && rx_full && !rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_overrun_evt) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (w_set_ferr) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (r_shift),
        .pop   (rd_en),
        .dout  (rd_data),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (12 MHz, 115200 baud).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    // DIV = round(12e6 / 1843200) = 7 clocks per tick, 16 ticks per bit.
    localparam int c_BIT = 112;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rx_bit  = 1'b1;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rx_full;
    logic [4:0] rx_count;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       odd_parity = 1'b0;
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_HZ     (12000000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_bit     (rx_bit),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_count   (rx_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .odd_parity (odd_parity),
        .parity_err (parity_err),
`endif
        .clr_err    (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit plus 8 data bits; returns on the negedge where the next bit begins.
    task automatic send_head(input logic [7:0] d);
        rx_bit = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_bit = d[i];
            repeat (c_BIT) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_head(d);
        rx_bit = stop_v;
        repeat (c_BIT) @(negedge clk);
        rx_bit = 1'b1;
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        chk(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_empty",   32'(rx_empty),  32'd1);
        chk("rst_full",    32'(rx_full),   32'd0);
        chk("rst_count",   32'(rx_count),  32'd0);
        chk("rst_rd_data", 32'(rd_data),   32'h00);
        chk("rst_overrun", 32'(overrun),   32'd0);
        chk("rst_ferr",    32'(frame_err), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 0x41: push lands on the posedge 1080.5 clocks after the start edge
        send_head(8'h41);
        rx_bit = 1'b1;
        repeat (72) @(negedge clk);
        chk("t1_pre_push_empty", 32'(rx_empty), 32'd1);
        @(negedge clk);
        chk("t1_empty", 32'(rx_empty), 32'd0);
        chk("t1_data",  32'(rd_data),  32'h41);
        chk("t1_count", 32'(rx_count), 32'd1);
        repeat (c_BIT - 73) @(negedge clk);
        pop_byte("t1_pop", 8'h41);
        chk("t1_empty_after_pop", 32'(rx_empty), 32'd1);

        // False start: low for 3 sample ticks only
        rx_bit = 1'b0;
        repeat (21) @(negedge clk);
        rx_bit = 1'b1;
        repeat (2 * c_BIT) @(negedge clk);
        chk("t2_count",   32'(rx_count),  32'd0);
        chk("t2_empty",   32'(rx_empty),  32'd1);
        chk("t2_ferr",    32'(frame_err), 32'd0);
        chk("t2_overrun", 32'(overrun),   32'd0);

        // Framing error on 0x55
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        chk("t3_ferr",  32'(frame_err), 32'd1);
        chk("t3_empty", 32'(rx_empty),  32'd1);
        pulse_clr();
        chk("t3_ferr_clr", 32'(frame_err), 32'd0);

        // Overflow: 17 bytes into a 16-entry FIFO
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1);
        end
        repeat (20) @(negedge clk);
        chk("t4_full",    32'(rx_full),  32'd1);
        chk("t4_count",   32'(rx_count), 32'd16);
        chk("t4_overrun", 32'(overrun),  32'd1);
        for (int i = 0; i < 16; i++) begin
            pop_byte("t4_pop", 8'(i));
        end
        chk("t4_empty",         32'(rx_empty), 32'd1);
        chk("t4_overrun_stick", 32'(overrun),  32'd1);
        pulse_clr();
        chk("t4_overrun_clr", 32'(overrun), 32'd0);

        // Back-to-back frames, pop on the push cycle of the second byte
        send_frame(8'h00, 1'b1);
        send_head(8'hFF);
        rx_bit = 1'b1;
        repeat (72) @(negedge clk);
        chk("t5_count_pre", 32'(rx_count), 32'd1);
        chk("t5_head_pre",  32'(rd_data),  32'h00);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("t5_count_pp", 32'(rx_count), 32'd1);
        chk("t5_head_pp",  32'(rd_data),  32'hFF);
        repeat (c_BIT - 73) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_count", 32'(rx_count), 32'd2);
        pop_byte("t5_pop_ff", 8'hFF);
        pop_byte("t5_pop_a5", 8'hA5);
        chk("t5_empty",   32'(rx_empty), 32'd1);
        chk("t5_overrun", 32'(overrun),  32'd0);

        // Reset in the middle of 0x3C with state to clear
        send_frame(8'h5A, 1'b1);
        send_frame(8'h11, 1'b0);
        repeat (20) @(negedge clk);
        chk("t6_pre_count", 32'(rx_count),  32'd1);
        chk("t6_pre_ferr",  32'(frame_err), 32'd1);
        rx_bit = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_bit = (i == 2 || i == 3);
            repeat (c_BIT) @(negedge clk);
        end
        reset  = 1'b0;
        rx_bit = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_empty", 32'(rx_empty),  32'd1);
        chk("t6_rst_full",  32'(rx_full),   32'd0);
        chk("t6_rst_count", 32'(rx_count),  32'd0);
        chk("t6_rst_data",  32'(rd_data),   32'h00);
        chk("t6_rst_ferr",  32'(frame_err), 32'd0);
        chk("t6_rst_ovr",   32'(overrun),   32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h96, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_count", 32'(rx_count), 32'd1);
        pop_byte("t6_pop", 8'h96);
        chk("t6_empty", 32'(rx_empty), 32'd1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        odd_parity = 1'b0;
        send_head(8'h07);
        rx_bit = 1'b0;
        repeat (c_BIT) @(negedge clk);
        rx_bit = 1'b1;
        repeat (c_BIT) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t7_perr",  32'(parity_err), 32'd1);
        chk("t7_empty", 32'(rx_empty),   32'd1);
        chk("t7_ferr",  32'(frame_err),  32'd0);
        pulse_clr();
        chk("t7_perr_clr", 32'(parity_err), 32'd0);
        send_head(8'h07);
        rx_bit = 1'b1;
        repeat (c_BIT) @(negedge clk);
        repeat (c_BIT) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("t7_count", 32'(rx_count),   32'd1);
        chk("t7_perr2", 32'(parity_err), 32'd0);
        pop_byte("t7_pop", 8'h07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
